// File: rtl/dc_pattern_sink.sv
// rtl/dc_pattern_sink.sv - pattern-driven stream sink with sequence, colour and hold checks
// Optional stall watchdog: define DC_PATTERN_SINK_WDOG_EN.
module dc_pattern_sink #(
  parameter int SEQ_W     = 8,
  parameter int COLOR_W   = 2,
  parameter int COLOR_KEY = 0,
  parameter int CNT_W     = 16,
  parameter int WDOG_CYC  = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [15:0]              dst_pat,
  input  logic                     in_valid,
  input  logic [COLOR_W+SEQ_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     color_error,
  output logic                     seq_error,
  output logic                     hold_error,
  output logic [CNT_W-1:0]         beat_count,
  output logic [SEQ_W-1:0]         err_seq,
  output logic                     wdog_error
);

  localparam int DW = COLOR_W + SEQ_W;
  localparam logic [COLOR_W-1:0] KEY = COLOR_KEY[COLOR_W-1:0];

  logic [3:0]         slot;
  logic [SEQ_W-1:0]   exp_seq;
  logic               stalled;
  logic [DW-1:0]      cap_data;
  logic               fire;
  logic [SEQ_W-1:0]   rx_seq;
  logic [COLOR_W-1:0] rx_color;
  logic [COLOR_W-1:0] exp_color;
  logic               bad_seq;
  logic               bad_color;
  logic               bad_hold;
  logic               bad_wdog;
  logic               any_err;

  // Ready is gated by reset so nothing can be accepted while state is held clear.
  assign in_ready  = reset & dst_pat[slot];
  assign fire      = in_valid & in_ready;
  assign rx_seq    = in_data[SEQ_W-1:0];
  assign rx_color  = in_data[DW-1:SEQ_W];
  assign exp_color = exp_seq[COLOR_W-1:0] ^ KEY;
  assign bad_seq   = fire & (rx_seq != exp_seq);
  assign bad_color = fire & (rx_color != exp_color);
  assign bad_hold  = stalled & (~in_valid | (in_data != cap_data));
  assign any_err   = color_error | seq_error | hold_error | wdog_error;

`ifdef DC_PATTERN_SINK_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  localparam logic [WW-1:0] WLIM = WW'(WDOG_CYC);

  logic [WW-1:0] wdog_cnt;
  logic          wdog_q;

  assign bad_wdog   = (wdog_cnt == WLIM);
  assign wdog_error = wdog_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else begin
      if (!in_valid || fire)
        wdog_cnt <= '0;
      else if (wdog_cnt != WLIM)
        wdog_cnt <= wdog_cnt + 1'b1;
      if (bad_wdog)
        wdog_q <= 1'b1;
    end
  end
`else
  assign bad_wdog   = 1'b0;
  assign wdog_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot        <= '0;
      exp_seq     <= '0;
      stalled     <= 1'b0;
      cap_data    <= '0;
      color_error <= 1'b0;
      seq_error   <= 1'b0;
      hold_error  <= 1'b0;
      beat_count  <= '0;
      err_seq     <= '0;
    end else begin
      slot    <= slot + 1'b1;
      stalled <= in_valid & ~in_ready;
      if (in_valid && !in_ready)
        cap_data <= in_data;
      // exp_seq advances from itself so one skip is flagged without resync.
      if (fire) begin
        exp_seq    <= exp_seq + 1'b1;
        beat_count <= beat_count + 1'b1;
      end
      if (bad_seq)   seq_error   <= 1'b1;
      if (bad_color) color_error <= 1'b1;
      if (bad_hold)  hold_error  <= 1'b1;
      if (!any_err && (bad_seq || bad_color || bad_hold || bad_wdog))
        err_seq <= exp_seq;
    end
  end

endmodule
